// File: rtl/mux_arbiter4.sv
// rtl/mux_arbiter4.sv - round-robin arbiter driving a 4:1 mux select with tenure-limited preemption
module mux_arbiter4 #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] in,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       valid,
  output logic       out,
  output logic [9:0] LED
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0] HOLD_C = 4'(HOLD);

  state_t     state, state_nx;
  logic [1:0] owner, owner_nx;
  logic [1:0] last, last_nx;
  logic [3:0] cnt, cnt_nx;
  logic [1:0] winner;
  logic       others;

  // Search last+1, last+2, last+3, last; the lowest offset with req set wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    rr_pick = l;
    for (int k = 4; k >= 1; k--) begin
      idx = l + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    winner = rr_pick(req, last);
    others = |(req & ~(4'b0001 << owner));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= 2'd0;
      last   <= 2'd3;
      cnt    <= 4'd0;
      grant  <= 4'd0;
      select <= 2'd0;
      valid  <= 1'b0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      last   <= last_nx;
      cnt    <= cnt_nx;
      grant  <= (state_nx == GRANT) ? (4'b0001 << owner_nx) : 4'd0;
      select <= owner_nx;
      valid  <= (state_nx == GRANT);
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx = GRANT;
          owner_nx = winner;
          last_nx  = winner;
          cnt_nx   = 4'd1;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          // Release hands straight to the next requester, no idle bubble.
          if (|req) begin
            owner_nx = winner;
            last_nx  = winner;
            cnt_nx   = 4'd1;
          end else begin
            state_nx = IDLE;
          end
        end else if (cnt >= HOLD_C && others) begin
          owner_nx = winner;
          last_nx  = winner;
          cnt_nx   = 4'd1;
        end else if (cnt < HOLD_C) begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out = valid ? in[select] : 1'b0;
    LED = {select, grant, req};
  end

endmodule

// File: doc/mux_arbiter4.md
# mux_arbiter4

Round-robin arbiter and sequencer for the 4:1 multiplexer datapath. Four requesters compete for the shared mux. The block grants one requester at a time, drives the mux select lines from that grant, and forwards the granted input bit to `out`. A tenure limit prevents one requester from holding the mux indefinitely while others wait. LED mirrors expose request, grant and select state for bench and board debug.

## Interface
- HOLD, default 4: maximum tenure in cycles before preemption when a competitor is waiting; legal range 1..15.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  [3:0]  request lines, one per requester; level-sensitive.
- in  input  [3:0]  mux data inputs; in[i] belongs to requester i.
- grant  output  [3:0]  registered one-hot grant; all-zero when idle.
- select  output  [1:0]  registered mux select; equals the index of the granted requester.
- valid  output  1  registered; high while any grant is active.
- out  output  1  combinational: in[select] when valid = 1, else 0.
- LED  output  [9:0]  LED[3:0] = req, LED[7:4] = grant, LED[9:8] = select.

## Operation
- State machine has two states: IDLE and GRANT.
- Internal registers:
  - `owner` [1:0]: index of the current grantee.
  - `last` [1:0]: index of the most recent grantee.
  - `cnt` [3:0]: tenure counter.
- Round-robin search: examine indices last+1, last+2, last+3, last (mod 4). The first one with req set wins.
- IDLE:
  - If req = 0, remain in IDLE.
  - Otherwise move to GRANT with the search winner as owner. Set last = winner and cnt = 1.
- GRANT, evaluated each edge in this priority order:
  1. req[owner] = 0 (release): if another request is set, switch directly to the search winner with cnt = 1 and no idle bubble. Otherwise go to IDLE.
  2. cnt >= HOLD and another requester is set (preempt): switch to the search winner. The winner is never the current owner, because the owner is examined last. Set cnt = 1.
  3. Otherwise keep the current owner. cnt increments and saturates at HOLD.
- A switch updates grant, select, valid and last on the same edge. There is never a cycle in which two grants are active.
- Outputs in IDLE: grant = 0000, valid = 0. select holds its last value, but out is forced to 0.
- Reset: state = IDLE, grant = 0000, select = 00, valid = 0, last = 11 (requester 0 has first priority), cnt = 0. out = 0 and LED[7:4] = 0000 while reset is asserted.
- Asserting reset mid-tenure aborts the grant immediately, without waiting for a clock edge.

## Timing
- Latency from request to grant is 1 cycle: a req rising before edge N gives grant at edge N.
- Release latency is 1 cycle: dropping req[owner] before edge N removes or moves the grant at edge N.
- Tenure is at most HOLD cycles under contention.
- A waiting requester is granted within 3*HOLD + 1 cycles, provided it keeps req asserted.
- out follows changes on in combinationally within the same cycle. It follows select changes after the clock edge.
- Simultaneous release by the owner and a new request from another requester: the new requester is granted at the same edge.
- req changes that are glitch-free between edges have no effect until the next edge.
- Deassertion of reset is synchronous in effect: the first grant can occur at the first edge after reset falls.

## Test plan
- Reset then single request: reset held for 2 cycles, then req = 0100 → at the next edge grant = 0100, select = 10, valid = 1, and out = in[2] (set in = 0100, expect out = 1).
- Round-robin under full load, HOLD = 4: req = 1111 held after reset → grants go 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles.
- Early release with handoff: owner 0 granted; req = 0010 arrives, then req[0] drops at cycle 2 → grant = 0010 at the next edge with no idle cycle; cnt restarts, so it is preempted only 4 cycles later if others request.
- No competitor: req = 1000 held for 20 cycles → grant stays 1000 throughout with no preemption; dropping req gives grant = 0000 and valid = 0 at the next edge.
- Priority pointer: grant last given to 2, then idle, then req = 1011 → grant = 1000 (index 3 is searched first after 2).
- Asynchronous reset mid-tenure: grant = 0010 active, reset pulsed between edges → grant = 0000, valid = 0 and out = 0 immediately; after release, req = 1111 → grant = 0001.
